// File: rtl/regdst_wb_sequencer_if.sv
// Handshake bundle between the decode front end and the write-back sequencer.
// The master drives the instruction and memory status; the slave drives write-back control.
interface regdst_wb_sequencer_if;
   logic       start;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       busy;
   logic [2:0] reg_dst;
   logic       reg_write;
   logic [1:0] wb_src;
   logic       done;
   logic       illegal;
   logic       mem_err;

   modport master (
      output start, opcode, funct, mem_ready,
      input  busy, reg_dst, reg_write, wb_src, done, illegal, mem_err
   );

   modport slave (
      input  start, opcode, funct, mem_ready,
      output busy, reg_dst, reg_write, wb_src, done, illegal, mem_err
   );
endinterface

// File: rtl/regdst_wb_sequencer.sv
// Multi-cycle register-file write-back sequencer: DECODE, EXEC, optional MEM wait,
// then one or two write cycles (pop writes rt, then $sp) before a one-cycle done pulse.
module regdst_wb_sequencer #(
   parameter int         EXEC_CYCLES = 2,
   parameter int         MEM_TIMEOUT = 15,
   parameter logic [5:0] OP_PUSH     = 6'h1c,
   parameter logic [5:0] OP_POP      = 6'h1d
) (
   input logic                   clk,
   input logic                   reset,
   regdst_wb_sequencer_if.slave  bus
);

   localparam int CMAX = (EXEC_CYCLES > MEM_TIMEOUT) ? EXEC_CYCLES : MEM_TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] EXEC_LAST = CW'(EXEC_CYCLES - 1);
   localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_EXEC, S_MEMWAIT, S_WB1, S_WB2, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      C_R, C_JR, C_I, C_LW, C_JAL, C_PUSH, C_POP, C_ILL
   } cls_t;

   state_t        state, nxt;
   cls_t          cls, dec;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          ill_q, ill_nxt, merr_q, merr_nxt;

   // Only the class survives past IDLE; opcode/funct are not needed after decode.
   always_comb begin
      dec = C_ILL;
      case (bus.opcode)
         6'h00:                                    dec = (bus.funct == 6'h08) ? C_JR : C_R;
         6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f: dec = C_I;
         6'h23:                                    dec = C_LW;
         6'h03:                                    dec = C_JAL;
         default: begin
            if (bus.opcode == OP_PUSH)     dec = C_PUSH;
            else if (bus.opcode == OP_POP) dec = C_POP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cls    <= C_R;
         cnt    <= '0;
         ill_q  <= 1'b0;
         merr_q <= 1'b0;
      end else begin
         state  <= nxt;
         cnt    <= cnt_nxt;
         ill_q  <= ill_nxt;
         merr_q <= merr_nxt;
         if (state == S_IDLE && bus.start) cls <= dec;
      end
   end

   always_comb begin
      nxt           = state;
      cnt_nxt       = cnt;
      ill_nxt       = ill_q;
      merr_nxt      = merr_q;
      bus.busy      = 1'b1;
      bus.reg_write = 1'b0;
      bus.reg_dst   = 3'b000;
      bus.wb_src    = 2'b00;
      bus.done      = 1'b0;
      bus.illegal   = 1'b0;
      bus.mem_err   = 1'b0;
      case (state)
         S_IDLE: begin
            bus.busy = 1'b0;
            cnt_nxt  = '0;
            ill_nxt  = 1'b0;
            merr_nxt = 1'b0;
            if (bus.start) nxt = S_DECODE;
         end
         S_DECODE: begin
            cnt_nxt = '0;
            if (cls == C_ILL) begin
               nxt     = S_DONE;
               ill_nxt = 1'b1;
            end else begin
               nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cnt == EXEC_LAST) begin
               cnt_nxt = '0;
               case (cls)
                  C_LW, C_POP: nxt = S_MEMWAIT;
                  C_JR:        nxt = S_DONE;
                  default:     nxt = S_WB1;
               endcase
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_MEMWAIT: begin
            // Data arriving in the last allowed cycle still beats the timeout.
            if (bus.mem_ready) begin
               nxt = S_WB1;
            end else if (cnt == MEM_LAST) begin
               nxt      = S_DONE;
               merr_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_WB1: begin
            bus.reg_write = 1'b1;
            nxt = (cls == C_POP) ? S_WB2 : S_DONE;
            case (cls)
               C_R:    begin bus.reg_dst = 3'b011; bus.wb_src = 2'b00; end
               C_LW:   begin bus.reg_dst = 3'b000; bus.wb_src = 2'b01; end
               C_POP:  begin bus.reg_dst = 3'b000; bus.wb_src = 2'b01; end
               C_JAL:  begin bus.reg_dst = 3'b010; bus.wb_src = 2'b10; end
               C_PUSH: begin bus.reg_dst = 3'b001; bus.wb_src = 2'b11; end
               default: begin bus.reg_dst = 3'b000; bus.wb_src = 2'b00; end
            endcase
         end
         S_WB2: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 3'b001;
            bus.wb_src    = 2'b11;
            nxt           = S_DONE;
         end
         S_DONE: begin
            bus.done    = 1'b1;
            bus.illegal = ill_q;
            bus.mem_err = merr_q;
            nxt         = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_regdst_wb_sequencer.sv
// Directed bench for the write-back sequencer; cycle 0 is the cycle start is driven high.
module tb_regdst_wb_sequencer;

   logic clk, reset;
   int   checks = 0;
   int   passes = 0;

   logic       rw [0:31];
   logic [2:0] rd [0:31];
   logic [1:0] ws [0:31];
   logic       dn [0:31];
   logic       il [0:31];
   logic       me [0:31];
   logic       bz [0:31];

   regdst_wb_sequencer_if bus ();

   regdst_wb_sequencer #(
      .EXEC_CYCLES(2), .MEM_TIMEOUT(15), .OP_PUSH(6'h1c), .OP_POP(6'h1d)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one instruction for n cycles and records every output at the falling edge.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input int hold,
                      input int rdy, input int rst_c, input int s2, input logic [5:0] op2,
                      input int n);
      for (int c = 0; c < n; c++) begin
         bus.start     = (c <= hold) || (c == s2);
         bus.opcode    = (c == s2) ? op2 : op;
         bus.funct     = fn;
         bus.mem_ready = (c == rdy);
         reset         = (c == rst_c);
         @(negedge clk);
         rw[c] = bus.reg_write; rd[c] = bus.reg_dst; ws[c] = bus.wb_src;
         dn[c] = bus.done; il[c] = bus.illegal; me[c] = bus.mem_err; bz[c] = bus.busy;
         @(posedge clk); #1;
      end
      bus.start = 1'b0; bus.mem_ready = 1'b0; reset = 1'b0;
   endtask

   function automatic int nwr(input int n);
      int k = 0;
      for (int c = 0; c < n; c++) if (rw[c]) k++;
      return k;
   endfunction

   function automatic int ndn(input int n);
      int k = 0;
      for (int c = 0; c < n; c++) if (dn[c]) k++;
      return k;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else passes++;
      checks++; if (bus.reg_write !== 1'b0) $display("FAIL reset_wr got %b exp 0", bus.reg_write); else passes++;
      checks++; if ({bus.reg_dst, bus.wb_src} !== 5'b0) $display("FAIL reset_sel got %b exp 0", {bus.reg_dst, bus.wb_src}); else passes++;
      checks++; if ({bus.done, bus.illegal, bus.mem_err} !== 3'b0) $display("FAIL reset_flags got %b exp 000", {bus.done, bus.illegal, bus.mem_err}); else passes++;
      bus.start = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_rtype();
      int bad = 0;
      run(6'h00, 6'h20, 0, -1, -1, -1, 6'h00, 8);
      checks++; if (bz[1] !== 1'b1) $display("FAIL r_busy1 got %b exp 1", bz[1]); else passes++;
      checks++; if ({rw[4], rd[4], ws[4]} !== 6'b1_011_00) $display("FAIL r_wb1 got %b exp 101100", {rw[4], rd[4], ws[4]}); else passes++;
      checks++; if (dn[5] !== 1'b1 || dn[4] !== 1'b0) $display("FAIL r_done got %b%b exp 10", dn[5], dn[4]); else passes++;
      checks++; if (bz[6] !== 1'b0 || bz[5] !== 1'b1) $display("FAIL r_busy_end got %b%b exp 10", bz[5], bz[6]); else passes++;
      checks++; if (nwr(8) !== 1) $display("FAIL r_writes got %0d exp 1", nwr(8)); else passes++;
      for (int c = 0; c < 8; c++) if (!rw[c] && (rd[c] !== 3'b0 || ws[c] !== 2'b0)) bad++;
      checks++; if (bad !== 0) $display("FAIL r_idle_sel got %0d exp 0", bad); else passes++;
   endtask

   task automatic test_itype_jal_push();
      run(6'h0d, 6'h00, 0, -1, -1, -1, 6'h00, 7);
      checks++; if ({rw[4], rd[4], ws[4]} !== 6'b1_000_00) $display("FAIL ori_wb got %b exp 100000", {rw[4], rd[4], ws[4]}); else passes++;
      run(6'h03, 6'h00, 0, -1, -1, -1, 6'h00, 7);
      checks++; if ({rw[4], rd[4], ws[4]} !== 6'b1_010_10) $display("FAIL jal_wb got %b exp 101010", {rw[4], rd[4], ws[4]}); else passes++;
      checks++; if (dn[5] !== 1'b1) $display("FAIL jal_done got %b exp 1", dn[5]); else passes++;
      run(6'h1c, 6'h00, 0, -1, -1, -1, 6'h00, 7);
      checks++; if ({rw[4], rd[4], ws[4]} !== 6'b1_001_11) $display("FAIL push_wb got %b exp 100111", {rw[4], rd[4], ws[4]}); else passes++;
      checks++; if (nwr(7) !== 1) $display("FAIL push_writes got %0d exp 1", nwr(7)); else passes++;
   endtask

   task automatic test_jr();
      run(6'h00, 6'h08, 0, -1, -1, -1, 6'h00, 6);
      checks++; if (dn[4] !== 1'b1) $display("FAIL jr_done got %b exp 1", dn[4]); else passes++;
      checks++; if (nwr(6) !== 0) $display("FAIL jr_writes got %0d exp 0", nwr(6)); else passes++;
   endtask

   task automatic test_pop();
      run(6'h1d, 6'h00, 0, 6, -1, -1, 6'h00, 11);
      checks++; if ({rw[7], rd[7], ws[7]} !== 6'b1_000_01) $display("FAIL pop_wb1 got %b exp 100001", {rw[7], rd[7], ws[7]}); else passes++;
      checks++; if ({rw[8], rd[8], ws[8]} !== 6'b1_001_11) $display("FAIL pop_wb2 got %b exp 100111", {rw[8], rd[8], ws[8]}); else passes++;
      checks++; if (dn[9] !== 1'b1) $display("FAIL pop_done got %b exp 1", dn[9]); else passes++;
      checks++; if (nwr(11) !== 2) $display("FAIL pop_writes got %0d exp 2", nwr(11)); else passes++;
   endtask

   task automatic test_lw();
      run(6'h23, 6'h00, 0, 4, -1, -1, 6'h00, 8);
      checks++; if ({rw[5], rd[5], ws[5]} !== 6'b1_000_01) $display("FAIL lw_first_wb got %b exp 100001", {rw[5], rd[5], ws[5]}); else passes++;
      checks++; if (dn[6] !== 1'b1 || me[6] !== 1'b0) $display("FAIL lw_first_done got %b%b exp 10", dn[6], me[6]); else passes++;
      run(6'h23, 6'h00, 0, 18, -1, -1, 6'h00, 22);
      checks++; if ({rw[19], ws[19]} !== 3'b1_01) $display("FAIL lw_last_wb got %b exp 101", {rw[19], ws[19]}); else passes++;
      checks++; if (dn[20] !== 1'b1 || me[20] !== 1'b0) $display("FAIL lw_last_done got %b%b exp 10", dn[20], me[20]); else passes++;
   endtask

   task automatic test_timeout();
      run(6'h23, 6'h00, 0, -1, -1, -1, 6'h00, 21);
      checks++; if (bz[18] !== 1'b1 || dn[18] !== 1'b0) $display("FAIL to_wait got %b%b exp 10", bz[18], dn[18]); else passes++;
      checks++; if (dn[19] !== 1'b1 || me[19] !== 1'b1) $display("FAIL to_done got %b%b exp 11", dn[19], me[19]); else passes++;
      checks++; if (nwr(21) !== 0) $display("FAIL to_writes got %0d exp 0", nwr(21)); else passes++;
      // A ready pulse during EXEC must not satisfy the memory wait.
      run(6'h23, 6'h00, 0, 3, -1, -1, 6'h00, 21);
      checks++; if (me[19] !== 1'b1 || nwr(21) !== 0) $display("FAIL early_ready got %b/%0d exp 1/0", me[19], nwr(21)); else passes++;
   endtask

   task automatic test_illegal();
      run(6'h3f, 6'h00, 0, -1, -1, -1, 6'h00, 4);
      checks++; if ({dn[2], il[2], me[2]} !== 3'b110) $display("FAIL ill_done got %b exp 110", {dn[2], il[2], me[2]}); else passes++;
      checks++; if (nwr(4) !== 0 || ndn(4) !== 1) $display("FAIL ill_counts got %0d/%0d exp 0/1", nwr(4), ndn(4)); else passes++;
   endtask

   task automatic test_start_held();
      run(6'h00, 6'h20, 5, -1, -1, -1, 6'h00, 12);
      checks++; if (ndn(12) !== 1) $display("FAIL held_done got %0d exp 1", ndn(12)); else passes++;
      checks++; if (nwr(12) !== 1 || bz[6] !== 1'b0) $display("FAIL held_wr got %0d/%b exp 1/0", nwr(12), bz[6]); else passes++;
   endtask

   task automatic test_mid_reset();
      run(6'h00, 6'h20, 0, -1, 3, -1, 6'h00, 8);
      checks++; if (bz[4] !== 1'b0) $display("FAIL rst_busy got %b exp 0", bz[4]); else passes++;
      checks++; if (nwr(8) !== 0 || ndn(8) !== 0) $display("FAIL rst_activity got %0d/%0d exp 0/0", nwr(8), ndn(8)); else passes++;
   endtask

   task automatic test_back_to_back();
      run(6'h00, 6'h20, 0, -1, -1, 6, 6'h03, 13);
      checks++; if (bz[7] !== 1'b1) $display("FAIL b2b_accept got %b exp 1", bz[7]); else passes++;
      checks++; if ({rw[10], rd[10], ws[10]} !== 6'b1_010_10) $display("FAIL b2b_wb got %b exp 101010", {rw[10], rd[10], ws[10]}); else passes++;
      checks++; if (dn[11] !== 1'b1 || ndn(13) !== 2) $display("FAIL b2b_done got %b/%0d exp 1/2", dn[11], ndn(13)); else passes++;
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.opcode = 6'h00; bus.funct = 6'h00; bus.mem_ready = 1'b0;
      test_reset();
      test_rtype();
      test_itype_jal_push();
      test_jr();
      test_pop();
      test_lw();
      test_timeout();
      test_illegal();
      test_start_held();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
